bitmap_column_reader: RTL and testbench

BITMAP_COLUMN_READER -- requirements
Module: bitmap_column_reader

---
 rtl/bitmap_column_reader.sv | 98 +++++++++
 tb/tb_bitmap_column_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_column_reader.sv
// Streams a swatch of 256-bit bitmap words from RAM port B to the nozzle drivers,
// one word per column-advance strobe, with wrap-around addressing and overrun flagging.
module bitmap_column_reader #(
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         arm,
    input  logic [11:0]  start_addr,
    input  logic [11:0]  end_addr,
    input  logic         col_adv,
    input  logic         abort,
    output logic [11:0]  addrb,
    input  logic [255:0] dob,
    output logic [255:0] col_data,
    output logic         col_valid,
    output logic         busy,
    output logic         done,
    output logic [12:0]  col_count,
    output logic         overrun,
    output logic [1:0]   dbg_state
);

    // Handshake: arm/col_adv/abort are single-cycle strobes sampled on the rising
    // edge; col_valid is a one-cycle pulse coincident with the new col_data.
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, READY = 2'd2, DONE = 2'd3} state_t;

    state_t         state, state_nxt;
    logic [11:0]    end_q;
    logic [255:0]   buf_q;
    logic           lat_cnt;
    logic           fetch_done;
    logic           arm_ok;
    logic           deliver;
    logic           last;

    assign fetch_done = (lat_cnt == 1'(RD_LAT - 1));
    assign arm_ok     = arm && !abort && (state == IDLE || state == DONE);
    assign deliver    = col_adv && (state == READY);
    // addrb still names the buffered word while in READY
    assign last       = (addrb == end_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (arm_ok) state_nxt = FETCH;
            FETCH:      if (fetch_done) state_nxt = READY;
            READY:      if (deliver) state_nxt = last ? DONE : FETCH;
            default:    state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        busy      = (state == FETCH) || (state == READY);
        done      = (state == DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrb     <= '0;
            end_q     <= '0;
            buf_q     <= '0;
            lat_cnt   <= 1'b0;
            col_data  <= '0;
            col_valid <= 1'b0;
            col_count <= '0;
            overrun   <= 1'b0;
        end else begin
            col_valid <= deliver;
            if (arm_ok) begin
                end_q     <= end_addr;
                addrb     <= start_addr;
                col_count <= '0;
                overrun   <= 1'b0;
                lat_cnt   <= 1'b0;
            end
            if (state == FETCH) begin
                if (!fetch_done) lat_cnt <= lat_cnt + 1'b1;
                else if (!abort) buf_q <= dob;
                if (col_adv) overrun <= 1'b1;
            end
            if (deliver) begin
                col_data  <= buf_q;
                col_count <= col_count + 13'd1;
                lat_cnt   <= 1'b0;
                if (!last) addrb <= addrb + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_bitmap_column_reader.sv
// Directed bench for bitmap_column_reader: table of swatch runs plus hand-written
// sequences for overrun, abort, asynchronous reset and the two-cycle RAM latency.
module tb_bitmap_column_reader;

    localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_READY = 2'd2, S_DONE = 2'd3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         arm = 1'b0, col_adv = 1'b0, abort = 1'b0;
    logic [11:0]  start_addr = '0, end_addr = '0;
    logic [11:0]  addrb;
    logic [255:0] dob, col_data;
    logic         col_valid, busy, done, overrun;
    logic [12:0]  col_count;
    logic [1:0]   dbg_state;

    logic         arm2 = 1'b0, col_adv2 = 1'b0;
    logic [11:0]  addrb2;
    logic [255:0] dob2 = '0, col_data2;
    logic         col_valid2, busy2, done2, overrun2;
    logic [12:0]  col_count2;
    logic [1:0]   dbg_state2;

    int checks = 0;
    int failures = 0;
    logic [255:0] exp_q[$];
    logic [255:0] exp2_q[$];

    typedef struct {
        logic [11:0] s;
        logic [11:0] e;
        int          n;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    bitmap_column_reader #(.RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .arm(arm), .start_addr(start_addr), .end_addr(end_addr),
        .col_adv(col_adv), .abort(abort), .addrb(addrb), .dob(dob), .col_data(col_data),
        .col_valid(col_valid), .busy(busy), .done(done), .col_count(col_count),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    bitmap_column_reader #(.RD_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .arm(arm2), .start_addr(start_addr), .end_addr(end_addr),
        .col_adv(col_adv2), .abort(1'b0), .addrb(addrb2), .dob(dob2), .col_data(col_data2),
        .col_valid(col_valid2), .busy(busy2), .done(done2), .col_count(col_count2),
        .overrun(overrun2), .dbg_state(dbg_state2)
    );

    function automatic logic [255:0] word(input logic [11:0] a);
        return {16{4'h0, a}};
    endfunction

    // RAM models: latency 1 is visible within the cycle, latency 2 adds a register
    always_comb dob = word(addrb);
    always_ff @(posedge clk) dob2 <= word(addrb2);

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (col_valid) begin
            if (exp_q.size() == 0) chk("unexpected_col_valid", 1, 0);
            else chk("col_data", col_data, exp_q.pop_front());
        end
        if (col_valid2) begin
            if (exp2_q.size() == 0) chk("unexpected_col_valid_lat2", 1, 0);
            else chk("col_data_lat2", col_data2, exp2_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_adv();
        col_adv = 1'b1;
        tick();
        col_adv = 1'b0;
    endtask

    task automatic run_swatch(input logic [11:0] s, input logic [11:0] e, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(word(s + 12'(i)));
        start_addr = s;
        end_addr   = e;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_addrb", addrb, s);
        chk("arm_busy", busy, 1);
        chk("arm_count_clear", col_count, 0);
        tick();
        chk("ready_after_lat1", dbg_state, S_READY);
        for (int k = 0; k < 20 && !done; k++) begin
            pulse_adv();
            repeat (9) tick();
        end
        chk("run_count", col_count, 13'(n));
        chk("run_done", done, 1);
        chk("run_busy", busy, 0);
        chk("run_overrun", overrun, 0);
        chk("run_addrb_frozen", addrb, e);
        chk("run_missing_cols", exp_q.size(), 0);
        pulse_adv();
        repeat (3) tick();
        chk("done_adv_count", col_count, 13'(n));
        chk("done_adv_overrun", overrun, 0);
        chk("done_hold", dbg_state, S_DONE);
    endtask

    initial begin
        vecs[0] = '{s: 12'h010, e: 12'h013, n: 4};
        vecs[1] = '{s: 12'hFFE, e: 12'h001, n: 4};
        vecs[2] = '{s: 12'h100, e: 12'h100, n: 1};
        vecs[3] = '{s: 12'h7F0, e: 12'h7F2, n: 3};

        repeat (2) tick();
        chk("rst_addrb", addrb, 0);
        chk("rst_col_data", col_data, 0);
        chk("rst_col_valid", col_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", col_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_state", dbg_state, S_IDLE);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) run_swatch(vecs[v].s, vecs[v].e, vecs[v].n);

        // col_adv landing in FETCH right after a delivered column
        exp_q.push_back(word(12'h200));
        exp_q.push_back(word(12'h201));
        start_addr = 12'h200;
        end_addr   = 12'h203;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        col_adv = 1'b1;
        tick();
        chk("ovr_in_fetch", dbg_state, S_FETCH);
        tick();
        col_adv = 1'b0;
        chk("ovr_set", overrun, 1);
        chk("ovr_count_held", col_count, 1);
        repeat (3) tick();
        pulse_adv();
        tick();
        chk("ovr_pending_delivered", col_count, 2);
        chk("ovr_sticky", overrun, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ovr_abort_idle", dbg_state, S_IDLE);

        // abort after two of eight columns, then re-arm
        exp_q.push_back(word(12'h300));
        exp_q.push_back(word(12'h301));
        start_addr = 12'h300;
        end_addr   = 12'h307;
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (2) begin
            repeat (4) tick();
            pulse_adv();
        end
        repeat (4) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_state", dbg_state, S_IDLE);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_count_kept", col_count, 2);
        chk("abort_data_kept", col_data, word(12'h301));
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        chk("abort_beats_arm", dbg_state, S_IDLE);
        chk("abort_beats_arm_count", col_count, 2);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("rearm_count", col_count, 0);
        chk("rearm_addrb", addrb, 12'h300);
        exp_q.push_back(word(12'h300));
        exp_q.push_back(word(12'h301));
        tick();
        pulse_adv();
        repeat (4) tick();
        col_adv = 1'b1; abort = 1'b1; tick(); col_adv = 1'b0; abort = 1'b0;
        chk("adv_abort_valid", col_valid, 1);
        chk("adv_abort_idle", dbg_state, S_IDLE);
        chk("adv_abort_count", col_count, 2);

        // asynchronous reset while READY
        exp_q.push_back(word(12'h400));
        start_addr = 12'h400;
        end_addr   = 12'h403;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        pulse_adv();
        repeat (4) tick();
        chk("pre_rst_ready", dbg_state, S_READY);
        reset = 1'b1;
        #1;
        chk("arst_state", dbg_state, S_IDLE);
        chk("arst_addrb", addrb, 0);
        chk("arst_col_data", col_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_count", col_count, 0);
        tick();
        reset = 1'b0;
        tick();
        pulse_adv();
        repeat (3) tick();
        chk("post_rst_count", col_count, 0);
        chk("post_rst_overrun", overrun, 0);

        // two-cycle RAM latency on the second instance
        for (int i = 0; i < 4; i++) exp2_q.push_back(word(12'h010 + 12'(i)));
        start_addr = 12'h010;
        end_addr   = 12'h013;
        arm2 = 1'b1; tick(); arm2 = 1'b0;
        chk("lat2_fetch1", dbg_state2, S_FETCH);
        tick();
        chk("lat2_fetch2", dbg_state2, S_FETCH);
        tick();
        chk("lat2_ready", dbg_state2, S_READY);
        for (int k = 0; k < 20 && !done2; k++) begin
            col_adv2 = 1'b1; tick(); col_adv2 = 1'b0;
            repeat (9) tick();
        end
        chk("lat2_count", col_count2, 4);
        chk("lat2_done", done2, 1);
        chk("lat2_overrun", overrun2, 0);
        chk("lat2_missing_cols", exp2_q.size(), 0);

        repeat (3) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
